// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_arb_pkg
//  Description : Shared types and defaults for the mem_loc two-port arbiter.
//                Provides the controller state encoding, the default address
//                and data widths, and the sizing rule for the read-latency
//                down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 7;
    localparam int DATA_W_DEF   = 8;
    localparam int READ_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // The counter is loaded with READ_LAT-1, so it never needs to hold
    // READ_LAT itself. At least one bit is kept so the signal is always legal.
    function automatic int lat_cnt_w(input int read_lat);
        return (read_lat > 1) ? $clog2(read_lat) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loc_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin grant.
//                When both requesters are valid, the one that was NOT granted
//                most recently (i_last) wins. A lone valid requester is
//                granted regardless of i_last.
//  Ports       : i_valid0 / i_valid1 - request valid per port
//                i_last              - port that received the previous grant
//                o_grant[1:0]        - one-hot grant (bit n = port n)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_loc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loc_arbiter
//  Description : Two-requester round-robin access controller for one mem_loc
//                instance. Accepts a request in IDLE, registers it onto the
//                memory port, waits out the read latency and returns the read
//                byte to the owning port with a one-cycle rvalid pulse.
//  Ports       : clk, rst_n            - clock, synchronous active-low reset
//                pX_valid/ready        - request handshake (X = 0, 1)
//                pX_we/addr/wdata      - request fields
//                pX_rvalid/rdata       - read response
//                mem_we/addr/data      - registered memory command
//                mem_out               - memory read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loc_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int              CNT_W    = lat_cnt_w(READ_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);
    localparam bit              LAT_ZERO = (READ_LAT == 0);

    state_e              state_q,     state_d;
    logic                last_q,      last_d;
    logic                port_q,      port_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q,  mem_data_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                p0_rvalid_q, p0_rvalid_d;
    logic                p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0]   p0_rdata_q,  p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q,  p1_rdata_d;

    logic [1:0]          w_grant;
    logic                w_accept0;
    logic                w_accept1;
    logic                w_sample;

    rr_arb2 u_rr_arb2 (
        .i_valid0 (p0_valid),
        .i_valid1 (p1_valid),
        .i_last   (last_q),
        .o_grant  (w_grant)
    );

    // Only one grant bit can be set, so at most one ready per cycle.
    assign p0_ready  = (state_q == IDLE) && w_grant[0];
    assign p1_ready  = (state_q == IDLE) && w_grant[1];
    assign w_accept0 = p0_valid && p0_ready;
    assign w_accept1 = p1_valid && p1_ready;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cnt_d       = cnt_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        w_sample    = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept0 || w_accept1) begin
                    port_d     = w_accept1;
                    last_d     = w_accept1;
                    mem_we_d   = w_accept1 ? p1_we    : p0_we;
                    mem_addr_d = w_accept1 ? p1_addr  : p0_addr;
                    mem_data_d = w_accept1 ? p1_wdata : p0_wdata;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d = IDLE;
                end else if (LAT_ZERO) begin
                    w_sample = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    w_sample = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The response is registered here so rvalid is high exactly in RESP;
        // the non-owning port's rdata is left untouched.
        if (w_sample) begin
            if (port_q) begin
                p1_rvalid_d = 1'b1;
                p1_rdata_d  = mem_out;
            end else begin
                p0_rvalid_d = 1'b1;
                p0_rdata_d  = mem_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cnt_q       <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cnt_q       <= cnt_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    // A write still sitting in ISSUE when reset arrives must not commit,
    // so the strobe is qualified by rst_n in the same cycle.
    assign mem_we    = mem_we_q && rst_n;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_loc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_loc_arbiter
//  Description : Self-checking bench for mem_loc_arbiter. A READ_LAT=1 and a
//                READ_LAT=0 instance each talk to a behavioural mem_loc.
//                Expected behaviour comes from a transaction-level model:
//                grant rule, fixed latencies and a reference memory image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loc_arbiter;

    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [6:0] p0_addr;
    logic [7:0] p0_wdata, p0_rdata;
    logic       p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [6:0] p1_addr;
    logic [7:0] p1_wdata, p1_rdata;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_data, mem_out;

    logic       z_p0_valid, z_p0_ready, z_p0_we, z_p0_rvalid;
    logic [6:0] z_p0_addr;
    logic [7:0] z_p0_wdata, z_p0_rdata;
    logic       z_p1_valid, z_p1_ready, z_p1_we, z_p1_rvalid;
    logic [6:0] z_p1_addr;
    logic [7:0] z_p1_wdata, z_p1_rdata;
    logic       z_mem_we;
    logic [6:0] z_mem_addr;
    logic [7:0] z_mem_data, z_mem_out;

    mem_loc_arbiter #(.ADDR_W(7), .DATA_W(8), .READ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
    );

    mem_loc_arbiter #(.ADDR_W(7), .DATA_W(8), .READ_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(z_p0_valid), .p0_ready(z_p0_ready), .p0_we(z_p0_we), .p0_addr(z_p0_addr),
        .p0_wdata(z_p0_wdata), .p0_rvalid(z_p0_rvalid), .p0_rdata(z_p0_rdata),
        .p1_valid(z_p1_valid), .p1_ready(z_p1_ready), .p1_we(z_p1_we), .p1_addr(z_p1_addr),
        .p1_wdata(z_p1_wdata), .p1_rvalid(z_p1_rvalid), .p1_rdata(z_p1_rdata),
        .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_data(z_mem_data), .mem_out(z_mem_out)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) ^ 8'h5C);
    endfunction

    // Behavioural mem_loc, one-cycle registered read.
    logic [7:0] mem_arr [128];
    logic       mem_init_done = 1'b0;
    logic [7:0] mem_out_q;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem_arr[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem_arr[mem_addr] <= mem_data;
        end
        mem_out_q <= mem_arr[mem_addr];
    end
    assign mem_out = mem_out_q;

    // Behavioural mem_loc, combinational read.
    logic [7:0] z_arr [128];
    logic       z_init_done = 1'b0;
    always @(posedge clk) begin
        if (!z_init_done) begin
            for (int i = 0; i < 128; i++) z_arr[i] <= init_val(i);
            z_init_done <= 1'b1;
        end else if (z_mem_we) begin
            z_arr[z_mem_addr] <= z_mem_data;
        end
    end
    assign z_mem_out = z_arr[z_mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference model.
    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } req_t;

    req_t       q0[$];
    req_t       q1[$];
    logic [7:0] ref_mem [128];
    logic       exp_last;
    logic [7:0] exp_rd0, exp_rd1;
    int         we_cnt;

    task automatic push(input int port, input logic we, input logic [6:0] a, input logic [7:0] d);
        req_t r;
        r.we = we; r.addr = a; r.data = d;
        if (port == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    task automatic model_reset();
        exp_last = 1'b1;
        exp_rd0  = 8'h00;
        exp_rd1  = 8'h00;
    endtask

    // Drains both request queues against the DUT. Entered and left just
    // after a rising edge. Each port holds valid while its queue is non-empty.
    task automatic run(input int limit);
        int         cyc, busy_until, wr_cyc, rd_iss, resp_cyc;
        logic       resp_port, v0, v1, g0, g1, free;
        logic [7:0] resp_dat, wr_dat;
        logic [6:0] wr_a, rd_a;
        req_t       r;
        cyc = 0; busy_until = 0; wr_cyc = -100; rd_iss = -100; resp_cyc = -100;
        resp_port = 1'b0; resp_dat = 8'h00; wr_dat = 8'h00; wr_a = 7'h00; rd_a = 7'h00;
        forever begin
            v0 = (q0.size() != 0);
            v1 = (q1.size() != 0);
            p0_valid = v0;
            p1_valid = v1;
            if (v0) begin r = q0[0]; p0_we = r.we; p0_addr = r.addr; p0_wdata = r.data; end
            if (v1) begin r = q1[0]; p1_we = r.we; p1_addr = r.addr; p1_wdata = r.data; end
            if (!v0 && !v1 && cyc >= busy_until) break;
            if (cyc >= limit) begin
                checks++;
                errors++;
                $error("FAIL run_timeout: observed %0d cycles required below %0d", cyc, limit);
                q0.delete(); q1.delete();
                break;
            end
            @(negedge clk);
            free = (cyc >= busy_until);
            g0 = free && v0 && (!v1 || exp_last);
            g1 = free && v1 && (!v0 || !exp_last);
            if (cyc == resp_cyc) begin
                if (resp_port) exp_rd1 = resp_dat;
                else           exp_rd0 = resp_dat;
            end
            check("p0_ready", 32'(p0_ready), 32'(g0));
            check("p1_ready", 32'(p1_ready), 32'(g1));
            check("mem_we", 32'(mem_we), 32'(cyc == wr_cyc));
            if (mem_we === 1'b1) we_cnt++;
            if (cyc == wr_cyc) begin
                check("wr_addr", 32'(mem_addr), 32'(wr_a));
                check("wr_data", 32'(mem_data), 32'(wr_dat));
            end
            if (cyc == rd_iss) check("rd_addr", 32'(mem_addr), 32'(rd_a));
            check("p0_rvalid", 32'(p0_rvalid), 32'(cyc == resp_cyc && !resp_port));
            check("p1_rvalid", 32'(p1_rvalid), 32'(cyc == resp_cyc && resp_port));
            check("p0_rdata", 32'(p0_rdata), 32'(exp_rd0));
            check("p1_rdata", 32'(p1_rdata), 32'(exp_rd1));
            if (g0 || g1) begin
                if (g1) r = q1.pop_front();
                else    r = q0.pop_front();
                exp_last = g1;
                if (r.we) begin
                    wr_cyc = cyc + 1; wr_a = r.addr; wr_dat = r.data;
                    ref_mem[r.addr] = r.data;
                    busy_until = cyc + 2;
                end else begin
                    rd_iss = cyc + 1; rd_a = r.addr;
                    resp_cyc = cyc + 2 + LAT; resp_port = g1;
                    resp_dat = ref_mem[r.addr];
                    busy_until = cyc + 3 + LAT;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    function automatic logic [6:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 7'h3F;
            1:       return 7'h40;
            2:       return 7'h7F;
            3:       return 7'h00;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        z_p0_valid = 1'b0; z_p0_we = 1'b0; z_p0_addr = '0; z_p0_wdata = '0;
        z_p1_valid = 1'b0; z_p1_we = 1'b0; z_p1_addr = '0; z_p1_wdata = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        model_reset();
        we_cnt = 0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_data", 32'(mem_data), 32'(0));
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'(0));
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'(0));
        check("rst_p0_rdata", 32'(p0_rdata), 32'(0));
        check("rst_p1_rdata", 32'(p1_rdata), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both ports valid straight out of reset: port 0 first.
        push(0, 1'b0, 7'h10, 8'h00);
        push(1, 1'b0, 7'h50, 8'h00);
        run(50);

        // Write then read back on port 0.
        push(0, 1'b1, 7'h05, 8'hA5);
        push(0, 1'b0, 7'h05, 8'h00);
        run(50);

        // Bank edge addresses.
        we_cnt = 0;
        push(1, 1'b1, 7'h3F, 8'h11);
        push(1, 1'b1, 7'h40, 8'h22);
        push(1, 1'b1, 7'h7F, 8'h33);
        push(0, 1'b0, 7'h3F, 8'h00);
        push(0, 1'b0, 7'h40, 8'h00);
        push(0, 1'b0, 7'h7F, 8'h00);
        run(100);
        check("edge_we_cycles", 32'(we_cnt), 32'(3));

        // Continuous contention: strict alternation.
        for (int i = 0; i < 8; i++) begin
            push(0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            push(1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        end
        run(200);

        // Randomised rounds with idle gaps.
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                push($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            run(400);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Reset during WAIT of a port 1 read.
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 7'h22;
        @(negedge clk);
        check("abort_p1_ready", 32'(p1_ready), 32'(1));
        @(posedge clk); #1;
        p1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_wait_rvalid", 32'(p1_rvalid), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_mem_we", 32'(mem_we), 32'(0));
        check("abort_mem_addr", 32'(mem_addr), 32'(0));
        check("abort_mem_data", 32'(mem_data), 32'(0));
        check("abort_p0_rvalid", 32'(p0_rvalid), 32'(0));
        check("abort_p1_rvalid", 32'(p1_rvalid), 32'(0));
        check("abort_p0_rdata", 32'(p0_rdata), 32'(0));
        check("abort_p1_rdata", 32'(p1_rdata), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rvalid", 32'(p1_rvalid), 32'(0));
        end
        @(posedge clk); #1;
        model_reset();
        push(0, 1'b0, 7'h22, 8'h00);
        push(1, 1'b0, 7'h40, 8'h00);
        run(50);

        // Reset while a write sits in ISSUE: the write must not land.
        push(0, 1'b1, 7'h33, 8'h5A);
        run(50);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 7'h33; p0_wdata = 8'h99;
        @(negedge clk);
        check("wabort_p0_ready", 32'(p0_ready), 32'(1));
        @(posedge clk); #1;
        p0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("wabort_mem_we", 32'(mem_we), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        push(1, 1'b0, 7'h33, 8'h00);
        run(50);

        // READ_LAT=0 instance: write 0x7E @0x00 then read it back.
        z_p0_valid = 1'b1; z_p0_we = 1'b1; z_p0_addr = 7'h00; z_p0_wdata = 8'h7E;
        @(negedge clk);
        check("z_wr_ready", 32'(z_p0_ready), 32'(1));
        @(posedge clk); #1;
        z_p0_valid = 1'b0;
        @(negedge clk);
        check("z_wr_mem_we", 32'(z_mem_we), 32'(1));
        check("z_wr_mem_addr", 32'(z_mem_addr), 32'(0));
        @(posedge clk); #1;
        z_p0_valid = 1'b1; z_p0_we = 1'b0; z_p0_addr = 7'h00;
        @(negedge clk);
        check("z_idle_mem_we", 32'(z_mem_we), 32'(0));
        check("z_rd_ready", 32'(z_p0_ready), 32'(1));
        @(posedge clk); #1;
        z_p0_valid = 1'b0;
        @(negedge clk);
        check("z_rd_rvalid_a1", 32'(z_p0_rvalid), 32'(0));
        @(negedge clk);
        check("z_rd_rvalid_a2", 32'(z_p0_rvalid), 32'(1));
        check("z_rd_rdata", 32'(z_p0_rdata), 32'(8'h7E));
        check("z_rd_p1_rvalid", 32'(z_p1_rvalid), 32'(0));
        @(negedge clk);
        check("z_rd_rvalid_a3", 32'(z_p0_rvalid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
